// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions: default width, per-stage chunk sizing and the result flag bundle.
package alu_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
    } flags_t;

    // Bits resolved per pipeline stage; a zero stage count yields zero so the caller's check can fire cleanly.
    function automatic int unsigned chunk_width(input int unsigned width, input int unsigned stages);
        return (stages == 0) ? 0 : width / stages;
    endfunction

endpackage

// File: rtl/add_slice.sv
// CHUNK-bit ripple-carry adder slice used once per pipeline stage.
module add_slice #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    logic [W:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int unsigned i = 0; i < W; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
        co = c[W];
    end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor: one CHUNK slice per stage, registered carry between slices,
// valid/ready handshake with whole-pipeline stall on backpressure.
module pipelined_adder
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);

    if ((STAGES == 0) || ((WIDTH % STAGES) != 0)) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a non-zero multiple of STAGES");
    end

    logic             adv;
    logic [WIDTH-1:0] b_inv;
    logic             ovf_d;
    logic             ovf_q;
    flags_t           flags;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign b_inv    = b ^ {WIDTH{sub}};

    for (genvar k = 0; k < STAGES; k++) begin : stg
        localparam int unsigned LO   = k * CHUNK;
        localparam int unsigned UPW  = WIDTH - LO;
        localparam int unsigned DONE = LO + CHUNK;

        logic [UPW-1:0]   up_a;
        logic [UPW-1:0]   up_b;
        logic             vi;
        logic             ci;
        logic [CHUNK-1:0] s_d;
        logic             co_d;
        logic [DONE-1:0]  s_cat;
        logic             v_q;
        logic             c_q;
        logic [DONE-1:0]  s_q;

        // Operand source: the ports for the first stage, the predecessor's registers otherwise.
        if (k == 0) begin : g_src
            assign vi    = in_valid;
            assign ci    = cin;
            assign up_a  = a;
            assign up_b  = b_inv;
            assign s_cat = s_d;
        end else begin : g_src
            assign vi    = stg[k-1].v_q;
            assign ci    = stg[k-1].c_q;
            assign up_a  = stg[k-1].g_fwd.ua_q;
            assign up_b  = stg[k-1].g_fwd.ub_q;
            assign s_cat = {s_d, stg[k-1].s_q};
        end

        add_slice #(.W(CHUNK)) u_slice (
            .x  (up_a[CHUNK-1:0]),
            .y  (up_b[CHUNK-1:0]),
            .ci (ci),
            .s  (s_d),
            .co (co_d)
        );

        // Data only loads for valid beats so outputs stay frozen across bubbles.
        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (adv) begin
                v_q <= vi;
                if (vi) begin
                    c_q <= co_d;
                    s_q <= s_cat;
                end
            end
        end

        if (k + 1 < STAGES) begin : g_fwd
            logic [UPW-CHUNK-1:0] ua_q;
            logic [UPW-CHUNK-1:0] ub_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    ua_q <= '0;
                    ub_q <= '0;
                end else if (adv && vi) begin
                    ua_q <= up_a[UPW-1:CHUNK];
                    ub_q <= up_b[UPW-1:CHUNK];
                end
            end
        end
    end

    // The final slice holds both operand sign bits, so overflow is resolved there.
    assign ovf_d = (stg[STAGES-1].up_a[CHUNK-1] == stg[STAGES-1].up_b[CHUNK-1]) &&
                   (stg[STAGES-1].s_d[CHUNK-1] != stg[STAGES-1].up_a[CHUNK-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (adv && stg[STAGES-1].vi) begin
            ovf_q <= ovf_d;
        end
    end

    assign out_valid  = stg[STAGES-1].v_q;
    assign sum        = stg[STAGES-1].s_q;
    assign flags.cout = stg[STAGES-1].c_q;
    assign flags.ovf  = ovf_q;
    assign flags.zero = (sum == '0);
    assign cout       = flags.cout;
    assign ovf        = flags.ovf;
    assign zero       = flags.zero;

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (WIDTH=32, STAGES=4): directed vectors, stalls, bubbles,
// mid-flight reset and a randomised backpressure run.
module tb_pipelined_adder;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic rnd_ready = 1'b0;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(32), .STAGES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] s, input logic c, input logic o, input logic z);
        exp_t e;
        e.sum  = s;
        e.cout = c;
        e.ovf  = o;
        e.zero = z;
        return e;
    endfunction

    function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv,
                                   input logic sv, input logic cv);
        logic [31:0] bb;
        logic [32:0] r;
        exp_t        e;
        bb     = bv ^ {32{sv}};
        r      = {1'b0, av} + {1'b0, bb} + 33'(cv);
        e.sum  = r[31:0];
        e.cout = r[32];
        e.ovf  = (av[31] == bb[31]) && (r[31] != av[31]);
        e.zero = (r[31:0] == 32'h0);
        return e;
    endfunction

    // Caller sits just after a rising edge; returns just after the edge that accepted the beat.
    task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                        input logic cv, input exp_t e);
        int n;
        n = 0;
        in_valid = 1'b1;
        a   = av;
        b   = bv;
        sub = sv;
        cin = cv;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
        else q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Random backpressure driver.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: pops the scoreboard on every transfer, and checks outputs are frozen otherwise.
    initial begin
        exp_t        e;
        logic [31:0] p_sum;
        logic        p_cout;
        logic        p_ovf;
        logic        p_valid;
        logic        p_ready;
        logic        p_rst;
        p_sum   = '0;
        p_cout  = 1'b0;
        p_ovf   = 1'b0;
        p_valid = 1'b0;
        p_ready = 1'b1;
        p_rst   = 1'b1;
        forever begin
            @(negedge clk);
            if (!p_rst && (!out_valid || (p_valid && !p_ready))) begin
                check("hold_sum", sum, p_sum);
                check("hold_flags", {30'd0, cout, ovf}, {30'd0, p_cout, p_ovf});
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_beat", 32'(out_valid), 32'd0);
                end else begin
                    e = q.pop_front();
                    check("sum", sum, e.sum);
                    check("cout", 32'(cout), 32'(e.cout));
                    check("ovf", 32'(ovf), 32'(e.ovf));
                    check("zero", 32'(zero), 32'(e.zero));
                end
            end
            p_sum   = sum;
            p_cout  = cout;
            p_ovf   = ovf;
            p_valid = out_valid;
            p_ready = out_ready;
            p_rst   = rst;
        end
    end

    initial begin
        int   n;
        logic exp_pat [4];
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", sum, 32'h0);
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Directed arithmetic, back-to-back.
        send(32'hFFFF_FFFF, 32'h1,         1'b0, 1'b0, mk(32'h0000_0000, 1'b1, 1'b0, 1'b1));
        send(32'h7FFF_FFFF, 32'h1,         1'b0, 1'b0, mk(32'h8000_0000, 1'b0, 1'b1, 1'b0));
        send(32'h5,         32'h7,         1'b1, 1'b1, mk(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0));
        send(32'h8000_0000, 32'h1,         1'b1, 1'b1, mk(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0));
        send(32'h9,         32'h9,         1'b1, 1'b1, mk(32'h0000_0000, 1'b1, 1'b0, 1'b1));
        send(32'h1234_5678, 32'h0FED_CBA8, 1'b0, 1'b0, mk(32'h2222_2220, 1'b0, 1'b0, 1'b0));
        idle(6);

        // Latency: carry-in rippling across every slice boundary.
        send(32'h00FF_FFFF, 32'h0, 1'b0, 1'b1, mk(32'h0100_0000, 1'b0, 1'b0, 1'b0));
        n = 1;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'd4);
        @(posedge clk); #1;
        idle(4);

        // Bubble pattern 1,0,1,0.
        send(32'h1, 32'h2, 1'b0, 1'b0, mk(32'h3, 1'b0, 1'b0, 1'b0));
        idle(1);
        send(32'h10, 32'h20, 1'b0, 1'b0, mk(32'h30, 1'b0, 1'b0, 1'b0));
        idle(1);
        exp_pat[0] = 1'b1;
        exp_pat[1] = 1'b0;
        exp_pat[2] = 1'b1;
        exp_pat[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bubble_out_valid", 32'(out_valid), 32'(exp_pat[i]));
            @(posedge clk); #1;
        end
        idle(4);

        // Backpressure: fill with 1+1, 2+2, 3+3 while downstream stalls.
        out_ready = 1'b0;
        send(32'h1, 32'h1, 1'b0, 1'b0, mk(32'h2, 1'b0, 1'b0, 1'b0));
        send(32'h2, 32'h2, 1'b0, 1'b0, mk(32'h4, 1'b0, 1'b0, 1'b0));
        send(32'h3, 32'h3, 1'b0, 1'b0, mk(32'h6, 1'b0, 1'b0, 1'b0));
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            @(negedge clk);
            n++;
        end
        check("stall_out_valid", 32'(out_valid), 32'd1);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_sum", sum, 32'h2);
        @(posedge clk); #1;
        idle(3);
        @(negedge clk);
        check("stall_hold_sum", sum, 32'h2);
        @(posedge clk); #1;
        out_ready = 1'b1;
        idle(6);

        // Reset with three beats in flight.
        send(32'hA, 32'hB, 1'b0, 1'b0, mk(32'h15, 1'b0, 1'b0, 1'b0));
        send(32'hC, 32'hD, 1'b0, 1'b0, mk(32'h19, 1'b0, 1'b0, 1'b0));
        send(32'hE, 32'hF, 1'b0, 1'b0, mk(32'h1D, 1'b0, 1'b0, 1'b0));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        @(negedge clk);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_sum", sum, 32'h0);
        check("flush_zero", 32'(zero), 32'd1);
        @(posedge clk); #1;
        idle(10);

        // Random operands under random backpressure.
        rnd_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            logic        rs;
            logic        rc;
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            send(ra, rb, rs, rc, model(ra, rb, rs, rc));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        rnd_ready = 1'b0;
        out_ready = 1'b1;

        n = 0;
        while (q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        check("drain_empty", 32'(q.size()), 32'd0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
